// File: rtl/mod_counter_pkg.sv
// Shared constants and next-count helper for the modulo-N counter family.
package mod_counter_pkg;

  localparam int unsigned DEFAULT_MODULUS = 5;
  localparam int unsigned DEFAULT_WIDTH   = 3;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Wrapping modulo step; the caller guarantees value < modulus.
  function automatic int unsigned next_count(input int unsigned value,
                                             input dir_e        dir,
                                             input int unsigned modulus);
    if (dir == DIR_UP) begin
      return (value >= modulus - 1) ? 0 : value + 1;
    end
    return (value == 0) ? modulus - 1 : value - 1;
  endfunction

endpackage

// File: rtl/modn_next_cell.sv
// Combinational next-state, load range check and terminal-count (borrow/carry) logic.
module modn_next_cell
  import mod_counter_pkg::*;
#(
  parameter int unsigned MODULUS = DEFAULT_MODULUS,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             load_err_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_d_o,
  output logic             zero_d_o,
  output logic             load_err_d_o,
  output logic             borrow_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic load_oor;
  logic terminal;
  dir_e dir;

  always_comb begin
    dir          = dir_e'(up_i);
    load_oor     = 32'(load_val_i) >= MODULUS;
    count_d_o    = count_i;
    load_err_d_o = load_err_i;

    if (load_i) begin
      if (load_oor) begin
        count_d_o    = LAST;
        load_err_d_o = 1'b1;
      end else begin
        count_d_o    = load_val_i;
        load_err_d_o = 1'b0;
      end
    end else if (en_i) begin
      count_d_o = WIDTH'(next_count(32'(count_i), dir, MODULUS));
    end

    // Zero is registered from the next value so it tracks Y with no lag.
    zero_d_o = (count_d_o == '0);
    terminal = (dir == DIR_UP) ? (count_i == LAST) : (count_i == '0);
    borrow_o = en_i & ~load_i & terminal;
  end

endmodule

// File: rtl/mod5_down_counter_sync.sv
// Synchronous modulo-MODULUS down counter with load, borrow, zero and load-error flags.
// Define MOD5_COUNTER_UPDOWN_EN to add the Up port (up/down counting, Borrow becomes carry when Up=1).
module mod5_down_counter_sync
  import mod_counter_pkg::*;
#(
  parameter int unsigned MODULUS = DEFAULT_MODULUS,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
`ifdef MOD5_COUNTER_UPDOWN_EN
  input  logic             Up,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             Borrow,
  output logic             Zero,
  output logic             LoadErr
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             zero_q, zero_d;
  logic             load_err_q, load_err_d;
  logic             up;

`ifdef MOD5_COUNTER_UPDOWN_EN
  assign up = Up;
`else
  assign up = 1'b0;
`endif

  modn_next_cell #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_next (
    .count_i      (count_q),
    .load_err_i   (load_err_q),
    .en_i         (En),
    .load_i       (Load),
    .load_val_i   (LoadVal),
    .up_i         (up),
    .count_d_o    (count_d),
    .zero_d_o     (zero_d),
    .load_err_d_o (load_err_d),
    .borrow_o     (Borrow)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q    <= '0;
      zero_q     <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      zero_q     <= zero_d;
      load_err_q <= load_err_d;
    end
  end

  assign Y       = count_q;
  assign Zero    = zero_q;
  assign LoadErr = load_err_q;

endmodule

// File: tb/tb_mod5_down_counter_sync.sv
// Scoreboard bench for mod5_down_counter_sync (MODULUS=5, WIDTH=3).
module tb_mod5_down_counter_sync;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       En;
  logic       Load;
  logic [2:0] LoadVal;
  logic [2:0] Y;
  logic       Borrow;
  logic       Zero;
  logic       LoadErr;
`ifdef MOD5_COUNTER_UPDOWN_EN
  logic       Up;
`endif

  typedef struct {
    logic [2:0] y;
    logic       zero;
    logic       err;
    string      tag;
  } exp_t;

  typedef struct {
    logic       en;
    logic       ld;
    logic [2:0] lv;
    logic [2:0] y;
    logic       err;
    logic       b;
  } step_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  step_t prio_tbl[2] = '{
    '{1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0},
    '{1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0}
  };

  step_t range_tbl[12] = '{
    '{1'b1, 1'b1, 3'd6, 3'd4, 1'b1, 1'b0},
    '{1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0},
    '{1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0},
    '{1'b1, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0},
    '{1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0},
    '{1'b1, 1'b0, 3'd0, 3'd4, 1'b1, 1'b1},
    '{1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0},
    '{1'b0, 1'b1, 3'd5, 3'd4, 1'b1, 1'b0},
    '{1'b0, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0},
    '{1'b1, 1'b1, 3'd7, 3'd4, 1'b1, 1'b0},
    '{1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0},
    '{1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b1}
  };

  step_t hold_tbl[7] = '{
    '{1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0},
    '{1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0},
    '{1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0},
    '{1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0},
    '{1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0},
    '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0},
    '{1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0}
  };

  mod5_down_counter_sync #(
    .MODULUS (5),
    .WIDTH   (3)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .En      (En),
    .Load    (Load),
    .LoadVal (LoadVal),
`ifdef MOD5_COUNTER_UPDOWN_EN
    .Up      (Up),
`endif
    .Y       (Y),
    .Borrow  (Borrow),
    .Zero    (Zero),
    .LoadErr (LoadErr)
  );

  always #5 Clock = ~Clock;

  task automatic test_reset();
    Reset = 1'b1; En = 1'b0; Load = 1'b0; LoadVal = '0;
`ifdef MOD5_COUNTER_UPDOWN_EN
    Up = 1'b0;
`endif
    #2;
    n_cmp++;
    if (Y !== 3'd0 || Zero !== 1'b1 || LoadErr !== 1'b0 || Borrow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: Y=%0d Zero=%0b LoadErr=%0b Borrow=%0b, required Y=0 Zero=1 LoadErr=0 Borrow=0",
               Y, Zero, LoadErr, Borrow);
    end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_count_sequence();
    int   exp_y[6] = '{4, 3, 2, 1, 0, 4};
    logic exp_b[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    @(negedge Clock);
    Reset = 1'b1; #1; Reset = 1'b0;
    En = 1'b1; Load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (Borrow !== exp_b[i]) begin
        n_bad++;
        $display("FAIL count_borrow[%0d]: Borrow=%0b required %0b", i, Borrow, exp_b[i]);
      end
      sb.push_back('{y: 3'(exp_y[i]), zero: (exp_y[i] == 0), err: 1'b0, tag: "count_seq"});
      @(posedge Clock); #1;
      e = sb.pop_front();
      n_cmp++;
      if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
        n_bad++;
        $display("FAIL %s[%0d]: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
                 e.tag, i, Y, Zero, LoadErr, e.y, e.zero, e.err);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    foreach (prio_tbl[i]) begin
      if (i > 0) @(negedge Clock);
      En = prio_tbl[i].en; Load = prio_tbl[i].ld; LoadVal = prio_tbl[i].lv;
      #1;
      n_cmp++;
      if (Borrow !== prio_tbl[i].b) begin
        n_bad++;
        $display("FAIL prio_borrow[%0d]: Borrow=%0b required %0b", i, Borrow, prio_tbl[i].b);
      end
      sb.push_back('{y: prio_tbl[i].y, zero: (prio_tbl[i].y == 3'd0), err: prio_tbl[i].err, tag: "load_prio"});
      @(posedge Clock); #1;
      e = sb.pop_front();
      n_cmp++;
      if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
        n_bad++;
        $display("FAIL %s[%0d]: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
                 e.tag, i, Y, Zero, LoadErr, e.y, e.zero, e.err);
      end
    end
  endtask

  task automatic test_load_range();
    exp_t e;
    foreach (range_tbl[i]) begin
      @(negedge Clock);
      En = range_tbl[i].en; Load = range_tbl[i].ld; LoadVal = range_tbl[i].lv;
      #1;
      n_cmp++;
      if (Borrow !== range_tbl[i].b) begin
        n_bad++;
        $display("FAIL range_borrow[%0d]: Borrow=%0b required %0b", i, Borrow, range_tbl[i].b);
      end
      sb.push_back('{y: range_tbl[i].y, zero: (range_tbl[i].y == 3'd0), err: range_tbl[i].err, tag: "load_range"});
      @(posedge Clock); #1;
      e = sb.pop_front();
      n_cmp++;
      if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
        n_bad++;
        $display("FAIL %s[%0d]: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
                 e.tag, i, Y, Zero, LoadErr, e.y, e.zero, e.err);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    foreach (hold_tbl[i]) begin
      @(negedge Clock);
      En = hold_tbl[i].en; Load = hold_tbl[i].ld; LoadVal = hold_tbl[i].lv;
      #1;
      n_cmp++;
      if (Borrow !== hold_tbl[i].b) begin
        n_bad++;
        $display("FAIL hold_borrow[%0d]: Borrow=%0b required %0b", i, Borrow, hold_tbl[i].b);
      end
      sb.push_back('{y: hold_tbl[i].y, zero: (hold_tbl[i].y == 3'd0), err: hold_tbl[i].err, tag: "hold"});
      @(posedge Clock); #1;
      e = sb.pop_front();
      n_cmp++;
      if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
        n_bad++;
        $display("FAIL %s[%0d]: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
                 e.tag, i, Y, Zero, LoadErr, e.y, e.zero, e.err);
      end
    end
  endtask

  task automatic test_reset_override();
    exp_t e;
    // Reach Y=3 with LoadErr set: out-of-range load gives 4, one decrement gives 3.
    @(negedge Clock);
    En = 1'b1; Load = 1'b1; LoadVal = 3'd6;
    @(negedge Clock);
    Load = 1'b0;
    sb.push_back('{y: 3'd3, zero: 1'b0, err: 1'b1, tag: "rst_setup"});
    @(posedge Clock); #1;
    e = sb.pop_front();
    n_cmp++;
    if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
      n_bad++;
      $display("FAIL %s: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
               e.tag, Y, Zero, LoadErr, e.y, e.zero, e.err);
    end
    @(negedge Clock);
    En = 1'b1; Load = 1'b1; LoadVal = 3'd2;
    #2; Reset = 1'b1; #1;
    n_cmp++;
    if (Y !== 3'd0 || Zero !== 1'b1 || LoadErr !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async_midcount: Y=%0d Zero=%0b LoadErr=%0b, required Y=0 Zero=1 LoadErr=0",
               Y, Zero, LoadErr);
    end
    sb.push_back('{y: 3'd0, zero: 1'b1, err: 1'b0, tag: "rst_over_load"});
    @(posedge Clock); #1;
    e = sb.pop_front();
    n_cmp++;
    if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
      n_bad++;
      $display("FAIL %s: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
               e.tag, Y, Zero, LoadErr, e.y, e.zero, e.err);
    end
    @(negedge Clock);
    Reset = 1'b0; Load = 1'b0; En = 1'b1;
    sb.push_back('{y: 3'd4, zero: 1'b0, err: 1'b0, tag: "rst_first_edge"});
    @(posedge Clock); #1;
    e = sb.pop_front();
    n_cmp++;
    if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
      n_bad++;
      $display("FAIL %s: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
               e.tag, Y, Zero, LoadErr, e.y, e.zero, e.err);
    end
  endtask

  task automatic test_random();
    int   m_y = 4;
    logic m_err = 1'b0;
    logic exp_b;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      En      = ($urandom_range(0, 3) != 0);
      Load    = ($urandom_range(0, 4) == 0);
      LoadVal = 3'($urandom_range(0, 7));
      exp_b   = En && !Load && (m_y == 0);
      if (Load) begin
        if (LoadVal >= 3'd5) begin
          m_y = 4; m_err = 1'b1;
        end else begin
          m_y = int'(LoadVal); m_err = 1'b0;
        end
      end else if (En) begin
        m_y = (m_y == 0) ? 4 : m_y - 1;
      end
      #1;
      n_cmp++;
      if (Borrow !== exp_b) begin
        n_bad++;
        $display("FAIL rand_borrow[%0d]: Borrow=%0b required %0b", i, Borrow, exp_b);
      end
      sb.push_back('{y: 3'(m_y), zero: (m_y == 0), err: m_err, tag: "random"});
      @(posedge Clock); #1;
      e = sb.pop_front();
      n_cmp++;
      if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
        n_bad++;
        $display("FAIL %s[%0d]: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
                 e.tag, i, Y, Zero, LoadErr, e.y, e.zero, e.err);
      end
    end
  endtask

`ifdef MOD5_COUNTER_UPDOWN_EN
  task automatic test_updown();
    int   exp_y[6] = '{1, 2, 3, 4, 0, 1};
    logic exp_c[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    @(negedge Clock);
    Reset = 1'b1; #1; Reset = 1'b0;
    Up = 1'b1; En = 1'b1; Load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (Borrow !== exp_c[i]) begin
        n_bad++;
        $display("FAIL up_carry[%0d]: Borrow=%0b required %0b", i, Borrow, exp_c[i]);
      end
      sb.push_back('{y: 3'(exp_y[i]), zero: (exp_y[i] == 0), err: 1'b0, tag: "up_seq"});
      @(posedge Clock); #1;
      e = sb.pop_front();
      n_cmp++;
      if (Y !== e.y || Zero !== e.zero || LoadErr !== e.err) begin
        n_bad++;
        $display("FAIL %s[%0d]: Y=%0d Zero=%0b LoadErr=%0b, required Y=%0d Zero=%0b LoadErr=%0b",
                 e.tag, i, Y, Zero, LoadErr, e.y, e.zero, e.err);
      end
      @(negedge Clock);
    end
    Up = 1'b0; En = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count_sequence();
    test_load_priority();
    test_load_range();
    test_hold();
    test_reset_override();
    test_random();
`ifdef MOD5_COUNTER_UPDOWN_EN
    test_updown();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod5_down_counter_sync.md
MOD5_DOWN_COUNTER_SYNC -- requirements
Module: mod5_down_counter_sync

Interface
REQ-001 SHALL have parameter MODULUS, default 5: count modulus; legal range 2..2**WIDTH.
REQ-002 SHALL have parameter WIDTH, default 3: count and load width in bits.
REQ-003 SHALL have port Clock, input, 1: rising-edge clock; all state updates occur on this edge.
REQ-004 SHALL have port Reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port En, input, 1: count enable.
REQ-006 SHALL have port Load, input, 1: synchronous parallel load strobe.
REQ-007 SHALL have port LoadVal, input, WIDTH: value to load.
REQ-008 SHALL have port Y, output, WIDTH: current count.
REQ-009 SHALL have port Borrow, output, 1: cascade borrow, combinational.
REQ-010 SHALL have port Zero, output, 1: registered flag, high when Y==0.
REQ-011 SHALL have port LoadErr, output, 1: sticky out-of-range load flag.

Function
REQ-012 SHALL count down synchronously: each enabled edge sets Y to Y-1; when Y==0, Y becomes MODULUS-1. Sequence for the default is 4,3,2,1,0,4.
REQ-013 SHALL hold Y unchanged when En=0 and Load=0.
REQ-014 SHALL give Load priority over En: on an edge with Load=1, Y takes LoadVal and no decrement occurs that cycle.
REQ-015 SHALL, when LoadVal >= MODULUS, load MODULUS-1 instead and set LoadErr=1 on the same edge.
REQ-016 SHALL clear LoadErr only on Reset or on an in-range load; LoadErr SHALL be unaffected by counting.
REQ-017 SHALL drive Borrow = En & ~Load & (Y==0): high exactly in the cycle whose edge wraps 0 to MODULUS-1; no registered delay.
REQ-018 SHALL update Zero on the same edge as Y, so Zero == (Y==0) at all times after the edge, with no extra cycle of latency.
REQ-019 SHALL never present a Y value >= MODULUS, including after load, reset or wrap.
REQ-020 SHALL use a fully synchronous update for all count state except Reset; no ripple clocking and no derived clocks.
REQ-021 SHALL NOT use a decoded terminal state as a reset source (no glitch-reset self-clearing).

Reset
REQ-022 SHALL, while Reset=1, force Y=0, Zero=1 and LoadErr=0 immediately, independent of Clock.
REQ-023 SHALL, on the first Clock edge after Reset deasserts with En=1, move Y to MODULUS-1.
REQ-024 SHALL let a Reset asserted mid-count override Load and En on the same edge.

Configuration
REQ-025 SHALL, with macro MOD5_COUNTER_UPDOWN_EN defined, add port Up (input, 1): Up=1 counts 0..MODULUS-1 then wraps to 0, and Borrow then signals carry (En & ~Load & Y==MODULUS-1).
REQ-026 SHALL, without MOD5_COUNTER_UPDOWN_EN, have no Up port and count down only as in REQ-012.

Structure
REQ-027 SHALL place default MODULUS and WIDTH constants, plus a function returning next count (value, direction), in shared package mod_counter_pkg.
REQ-028 SHALL isolate next-state and terminal-count logic in one sub-module, modn_next_cell (combinational).
REQ-029 SHALL hold count, Zero and LoadErr registers in the top module.

Verification
REQ-030 Reset=1 mid-count at Y=3 -> Y=0, Zero=1, LoadErr=0 before the next Clock edge.
REQ-031 En=1 for 6 edges from reset -> Y=4,3,2,1,0,4; Borrow high only in the cycle where Y=0; Zero high with Y=0.
REQ-032 Load=1, LoadVal=2, En=1 same edge -> Y=2, no decrement; next enabled edge -> Y=1.
REQ-033 Load=1, LoadVal=6 -> Y=4, LoadErr=1; LoadErr stays 1 while counting; Load LoadVal=1 -> LoadErr=0.
REQ-034 En toggled 0 for 3 edges at Y=2 -> Y holds at 2 and Borrow=0.
REQ-035 With MOD5_COUNTER_UPDOWN_EN, Up=1, 6 edges from Y=0 -> 1,2,3,4,0,1; carry high while Y=4.
